gen_arbiter: RTL
================

// Module: gen_arbiter
// PURPOSE
//  Shares the single wrapper write port between the fibonacci and timer generators.
//  Sequences generator enables from start/stop pulses and a mode select.
//  Round-robin mode hands over by quantum; writing is held while buffer_full is high.
//  After stop, waits for the buffer to drain before returning to idle.
//  Sits in the clock_1 domain, between fibonacci/timer and the wrapper data_1 port.
// PARAMETERS
//  DATA_W   16  width of f_out, t_out and data_1
//  QUANTUM  4   words accepted from one source before handover in round-robin (1..255)
// PORTS
//  clock         in   1       block clock; all inputs are synchronous to it
//  reset         in   1       synchronous, active-low reset (reset==0 at posedge resets)
//  start         in   1       one-cycle pulse: begin generation
//  stop          in   1       one-cycle pulse: stop generation and drain
//  mode          in   2       00 fib only, 01 timer only, 10 round-robin, 11 reserved
//  f_valid       in   1       fibonacci word valid
//  f_out         in   DATA_W  fibonacci word
//  t_valid       in   1       timer word valid
//  t_out         in   DATA_W  timer word
//  buffer_full   in   1       wrapper full
//  buffer_empty  in   1       wrapper empty
//  data_2_valid  in   1       wrapper read side still presenting a word
//  f_en          out  1       fibonacci enable
//  t_en          out  1       timer enable
//  data_1_en     out  1       write strobe to wrapper
//  data_1        out  DATA_W  write data to wrapper
//  gen_mod       out  2       10 fib granted, 01 timer granted, 00 none (held during DRAIN)
//  busy          out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset: state IDLE; f_en=t_en=data_1_en=0, data_1=0, gen_mod=00, busy=0; counters cleared.
//  - States: IDLE, GRANT_F, GRANT_T, HOLD_F, HOLD_T, DRAIN (registered, one-hot or binary).
//  - IDLE: start with mode 00/10 -> GRANT_F; mode 01 -> GRANT_T; mode 11 -> ignored.
//    mode is latched at start and ignored until the next IDLE.
//  - f_en = (state==GRANT_F); t_en = (state==GRANT_T). Enables are registered outputs.
//  - data_1/data_1_en: combinational mux of the granted source's out/valid.
//    Applies in GRANT_x and HOLD_x. Valid from the non-granted source is discarded.
//  - GRANT_x with buffer_full -> HOLD_x, with the enable low from the next cycle.
//    HOLD_x with !buffer_full -> GRANT_x. The quantum counter is preserved across HOLD.
//  - Round-robin: 8-bit count increments per accepted word (granted valid && !buffer_full).
//    When count reaches QUANTUM-1 and a word is accepted: count<=0 and switch GRANT_F<->GRANT_T.
//    On that edge the old enable drops and the new enable rises (zero idle cycles).
//  - Single-source modes never switch; the counter is unused.
//  - stop in any non-IDLE state -> DRAIN. Enables go low on the next edge; gen_mod holds its last value.
//  - DRAIN: leave for IDLE when buffer_empty && !data_2_valid; gen_mod<=00 on exit.
//  - start and stop in the same cycle: stop wins (start ignored when busy).
//  - stop in IDLE is ignored.
//  - buffer_full and the quantum boundary in the same cycle: the word is not accepted, so there is no switch; go to HOLD.
//  - Reset asserted mid-operation: everything returns to reset values on that edge; in-flight words are dropped.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs f_count and t_count (16 bits each).
//    Each counts accepted words per source, saturates at 16'hFFFF, and clears on reset or on start.
//  ARB_STATS_EN undefined: the ports and logic are absent; all other behaviour is identical.
// TESTING
//  T1 mode=00, start, f_valid every 2 cycles, buffer never full
//     -> f_en=1, t_en=0; every f_out appears on data_1 with data_1_en; gen_mod=10.
//  T2 mode=10, QUANTUM=4, both valid every cycle
//     -> 4 fib words, then 4 timer words, then fib again; no gap cycle at handover.
//  T3 GRANT_F, buffer_full high for 5 cycles after 2 words
//     -> HOLD_F, f_en=0; resumes to finish 2 more fib words before the switch.
//  T4 stop while running, buffer_empty low 10 cycles
//     -> DRAIN, enables 0, busy=1; IDLE one cycle after buffer_empty=1 && data_2_valid=0.
//  T5 start and stop same cycle in GRANT_T; start in mode 11
//     -> DRAIN; mode 11 start leaves IDLE with busy=0.
//  T6 reset=0 mid-GRANT_T; with ARB_STATS_EN, 70000 fib words
//     -> all outputs reset next edge; f_count saturates at 65535.

Source files
------------

// File: rtl/gen_arbiter.sv
// gen_arbiter: shares the wrapper write port between the fibonacci and timer generators.
// Define ARB_STATS_EN to add the per-source accepted-word counters o_f_count/o_t_count.
module gen_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned QUANTUM = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic              i_f_valid,
  input  logic [DATA_W-1:0] i_f_out,
  input  logic              i_t_valid,
  input  logic [DATA_W-1:0] i_t_out,
  input  logic              i_buffer_full,
  input  logic              i_buffer_empty,
  input  logic              i_data_2_valid,
  output logic              o_f_en,
  output logic              o_t_en,
  output logic              o_data_1_en,
  output logic [DATA_W-1:0] o_data_1,
  output logic [1:0]        o_gen_mod,
`ifdef ARB_STATS_EN
  output logic [15:0]       o_f_count,
  output logic [15:0]       o_t_count,
`endif
  output logic              o_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StGrantF,
    StGrantT,
    StHoldF,
    StHoldT,
    StDrain
  } state_e;

  localparam logic [7:0] QLastCnt = 8'(QUANTUM - 1);

  state_e     r_state;
  state_e     w_state_d;
  logic [1:0] r_mode;
  logic [7:0] r_q_cnt;
  logic       r_f_en;
  logic       r_t_en;
  logic [1:0] r_gen_mod;

  logic w_fib_side;
  logic w_tim_side;
  logic w_start_ok;
  logic w_accept;
  logic w_switch;

  // A source stays granted while held, so its words still reach the wrapper once full clears.
  always_comb begin
    w_fib_side  = (r_state == StGrantF) || (r_state == StHoldF);
    w_tim_side  = (r_state == StGrantT) || (r_state == StHoldT);
    w_start_ok  = (r_state == StIdle) && i_start && (i_mode != 2'b11);
    w_accept    = !i_buffer_full && ((w_fib_side && i_f_valid) || (w_tim_side && i_t_valid));
    w_switch    = w_accept && (r_mode == 2'b10) && (r_q_cnt == QLastCnt);
    o_data_1    = '0;
    o_data_1_en = 1'b0;
    if (w_fib_side) begin
      o_data_1    = i_f_out;
      o_data_1_en = i_f_valid;
    end else if (w_tim_side) begin
      o_data_1    = i_t_out;
      o_data_1_en = i_t_valid;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start_ok) w_state_d = (i_mode == 2'b01) ? StGrantT : StGrantF;
      end
      StGrantF: begin
        if (i_stop)             w_state_d = StDrain;
        else if (i_buffer_full) w_state_d = StHoldF;
        else if (w_switch)      w_state_d = StGrantT;
      end
      StGrantT: begin
        if (i_stop)             w_state_d = StDrain;
        else if (i_buffer_full) w_state_d = StHoldT;
        else if (w_switch)      w_state_d = StGrantF;
      end
      StHoldF: begin
        if (i_stop)              w_state_d = StDrain;
        else if (!i_buffer_full) w_state_d = w_switch ? StGrantT : StGrantF;
      end
      StHoldT: begin
        if (i_stop)              w_state_d = StDrain;
        else if (!i_buffer_full) w_state_d = w_switch ? StGrantF : StGrantT;
      end
      StDrain: begin
        // A repeated stop restarts the drain wait rather than racing the exit.
        if (!i_stop && i_buffer_empty && !i_data_2_valid) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_mode    <= 2'b00;
      r_q_cnt   <= '0;
      r_f_en    <= 1'b0;
      r_t_en    <= 1'b0;
      r_gen_mod <= 2'b00;
    end else begin
      r_state <= w_state_d;
      r_f_en  <= (w_state_d == StGrantF);
      r_t_en  <= (w_state_d == StGrantT);
      if (w_start_ok) r_mode <= i_mode;
      if (w_start_ok || w_switch) begin
        r_q_cnt <= '0;
      end else if (w_accept && (r_mode == 2'b10)) begin
        r_q_cnt <= r_q_cnt + 8'd1;
      end
      case (w_state_d)
        StGrantF, StHoldF: r_gen_mod <= 2'b10;
        StGrantT, StHoldT: r_gen_mod <= 2'b01;
        StDrain:           r_gen_mod <= r_gen_mod;
        default:           r_gen_mod <= 2'b00;
      endcase
    end
  end

  assign o_f_en    = r_f_en;
  assign o_t_en    = r_t_en;
  assign o_gen_mod = r_gen_mod;
  assign o_busy    = (r_state != StIdle);

`ifdef ARB_STATS_EN
  logic [15:0] r_f_count;
  logic [15:0] r_t_count;
  logic        w_f_acc;
  logic        w_t_acc;

  assign w_f_acc = w_fib_side && i_f_valid && !i_buffer_full;
  assign w_t_acc = w_tim_side && i_t_valid && !i_buffer_full;

  always_ff @(posedge i_clock) begin
    if (!i_reset || w_start_ok) begin
      r_f_count <= '0;
      r_t_count <= '0;
    end else begin
      if (w_f_acc && (r_f_count != 16'hFFFF)) r_f_count <= r_f_count + 16'd1;
      if (w_t_acc && (r_t_count != 16'hFFFF)) r_t_count <= r_t_count + 16'd1;
    end
  end

  assign o_f_count = r_f_count;
  assign o_t_count = r_t_count;
`endif

endmodule
